// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: CPU and debug read ports plus the shared ROM pair bus.
// slave is the arbiter side; master is the requester/ROM side.
interface rom_arbiter_if #(
    parameter int AW = 13
);
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic [15:0]   cpu_data;
    logic          cpu_ack;
    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic [15:0]   dbg_data;
    logic          dbg_ack;
    logic [AW-1:0] rom_a;
    logic          rom_ce_n;
    logic [7:0]    rom_d_hi;
    logic [7:0]    rom_d_lo;
    logic          busy;

    modport slave (
        input  cpu_req, cpu_addr, dbg_req, dbg_addr,
        input  rom_d_hi, rom_d_lo,
        output cpu_data, cpu_ack, dbg_data, dbg_ack,
        output rom_a, rom_ce_n, busy
    );

    modport master (
        output cpu_req, cpu_addr, dbg_req, dbg_addr,
        output rom_d_hi, rom_d_lo,
        input  cpu_data, cpu_ack, dbg_data, dbg_ack,
        input  rom_a, rom_ce_n, busy
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares a hi/lo 8Kx8 registered-output ROM pair between CPU and debug reads.
// Define ROM_ARB_RR_EN for round-robin arbitration; default is fixed CPU priority.
module rom_arbiter #(
    parameter int AW = 13
) (
    input  logic         clk,
    input  logic         reset,
    rom_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DATA
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_r;
    logic          owner;
    logic          cpu_ok;
    logic          dbg_ok;
    logic          grant;
    logic          win;
`ifdef ROM_ARB_RR_EN
    logic          ptr;
`endif

    assign bus.rom_a = addr_r;

    // Eligible requests (owner masked in its ack cycle) and the winner (1 = debug)
    always_comb begin
        cpu_ok = bus.cpu_req & ~bus.cpu_ack;
        dbg_ok = bus.dbg_req & ~bus.dbg_ack;
        grant  = cpu_ok | dbg_ok;
`ifdef ROM_ARB_RR_EN
        win    = (cpu_ok & dbg_ok) ? ptr : ~cpu_ok;
`else
        win    = ~cpu_ok;
`endif
    end

    // Access sequencer: grant, issue to ROM, capture registered ROM data, ack
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            addr_r       <= '0;
            owner        <= 1'b0;
            bus.rom_ce_n <= 1'b1;
            bus.cpu_ack  <= 1'b0;
            bus.dbg_ack  <= 1'b0;
            bus.cpu_data <= 16'h0000;
            bus.dbg_data <= 16'h0000;
            bus.busy     <= 1'b0;
`ifdef ROM_ARB_RR_EN
            ptr          <= 1'b0;
`endif
        end else begin
            bus.cpu_ack <= 1'b0;
            bus.dbg_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        addr_r       <= win ? bus.dbg_addr : bus.cpu_addr;
                        owner        <= win;
                        bus.rom_ce_n <= 1'b0;
                        bus.busy     <= 1'b1;
                        state        <= ISSUE;
`ifdef ROM_ARB_RR_EN
                        ptr          <= ~win;
`endif
                    end
                end
                ISSUE: begin
                    bus.rom_ce_n <= 1'b1;
                    state        <= DATA;
                end
                DATA: begin
                    if (owner) begin
                        bus.dbg_data <= {bus.rom_d_hi, bus.rom_d_lo};
                        bus.dbg_ack  <= 1'b1;
                    end else begin
                        bus.cpu_data <= {bus.rom_d_hi, bus.rom_d_lo};
                        bus.cpu_ack  <= 1'b1;
                    end
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.rom_ce_n <= 1'b1;
                    bus.busy     <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: vector table, directed corner sequences and a random run
// checked against a transaction-level model of the arbiter.
module tb_rom_arbiter;
    localparam int AW = 13;
`ifdef ROM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] exp_cd;
    logic [15:0] exp_dd;

    rom_arbiter_if #(.AW(AW)) bus ();

    rom_arbiter #(.AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(logic [AW-1:0] a);
        if (a == 13'h0010) return 16'hA55A;
        return {3'b101, a};
    endfunction

    // Behavioural ROM pair: registers the addressed word when enabled
    always @(posedge clk) begin
        if (!bus.rom_ce_n) {bus.rom_d_hi, bus.rom_d_lo} <= rom_word(bus.rom_a);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic obs(string nm, bit ce_n, bit bsy, bit cack, bit dack);
        chk({nm, " ce_n/busy/cack/dack"},
            {28'd0, bus.rom_ce_n, bus.busy, bus.cpu_ack, bus.dbg_ack},
            {28'd0, ce_n, bsy, cack, dack});
    endtask

    task automatic chk_data(string nm);
        chk({nm, " cpu_data"}, {16'd0, bus.cpu_data}, {16'd0, exp_cd});
        chk({nm, " dbg_data"}, {16'd0, bus.dbg_data}, {16'd0, exp_dd});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.cpu_req  = 1'b0;
        bus.dbg_req  = 1'b0;
        bus.cpu_addr = '0;
        bus.dbg_addr = '0;
        tick();
        reset  = 1'b0;
        exp_cd = 16'h0000;
        exp_dd = 16'h0000;
    endtask

    task automatic run_single(string nm, bit dbg, logic [12:0] a, logic [15:0] d);
        if (dbg) begin
            bus.dbg_req  = 1'b1;
            bus.dbg_addr = a;
        end else begin
            bus.cpu_req  = 1'b1;
            bus.cpu_addr = a;
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 3) begin
                if (dbg) exp_dd = d;
                else exp_cd = d;
                bus.cpu_req = 1'b0;
                bus.dbg_req = 1'b0;
            end
            obs($sformatf("%s c%0d", nm, c), c != 1, c == 1 || c == 2,
                !dbg && c == 3, dbg && c == 3);
            chk_data($sformatf("%s c%0d", nm, c));
        end
    endtask

    function automatic logic [12:0] pick_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 13'h0000;
        if (r == 1) return 13'h1FFF;
        if (r == 2) return 13'h0010;
        return 13'($urandom);
    endfunction

    typedef struct {
        bit          dbg;
        logic [12:0] addr;
        logic [15:0] data;
    } vec_t;

    vec_t vt[6];

    initial begin
        bit w;
        vt[0] = '{1'b0, 13'h0010, 16'hA55A};
        vt[1] = '{1'b1, 13'h0010, 16'hA55A};
        vt[2] = '{1'b0, 13'h0000, 16'hA000};
        vt[3] = '{1'b1, 13'h1FFF, 16'hBFFF};
        vt[4] = '{1'b0, 13'h1234, 16'hB234};
        vt[5] = '{1'b1, 13'h0ABC, 16'hAABC};

        do_reset();
        obs("reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("reset rom_a", {19'd0, bus.rom_a}, 32'd0);
        chk_data("reset");

        for (int i = 0; i < 6; i++)
            run_single($sformatf("vec%0d", i), vt[i].dbg, vt[i].addr, vt[i].data);

        // Simultaneous requests from reset: CPU first, debug granted in CPU ack cycle
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h0001;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 13'h1FFF;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) begin
                bus.cpu_req = 1'b0;
                exp_cd      = 16'hA001;
            end
            if (c == 6) begin
                bus.dbg_req = 1'b0;
                exp_dd      = 16'hBFFF;
            end
            obs($sformatf("simul c%0d", c), !(c == 1 || c == 4),
                c == 1 || c == 2 || c == 4 || c == 5, c == 3, c == 6);
            chk_data($sformatf("simul c%0d", c));
        end

        // Both requests held continuously: acks alternate every 3 cycles
        do_reset();
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h0010;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 13'h0ABC;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (c == 3) exp_cd = 16'hA55A;
            if (c == 6) exp_dd = 16'hAABC;
            obs($sformatf("held2 c%0d", c), c % 3 != 1, c % 3 != 0,
                c == 3 || c == 9, c == 6 || c == 12);
            chk_data($sformatf("held2 c%0d", c));
        end

        // Tie after a CPU grant: round-robin favours debug, fixed favours CPU
        do_reset();
        run_single("pre", 1'b0, 13'h0001, 16'hA001);
        w            = RR;
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h0000;
        bus.dbg_req  = 1'b1;
        bus.dbg_addr = 13'h1FFF;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3 || c == 6) begin
                if ((c == 3) == w) begin
                    bus.dbg_req = 1'b0;
                    exp_dd      = 16'hBFFF;
                end else begin
                    bus.cpu_req = 1'b0;
                    exp_cd      = 16'hA000;
                end
            end
            obs($sformatf("tie c%0d", c), !(c == 1 || c == 4),
                c == 1 || c == 2 || c == 4 || c == 5,
                (c == 3 && !w) || (c == 6 && w), (c == 3 && w) || (c == 6 && !w));
            chk_data($sformatf("tie c%0d", c));
        end

        // CPU request held through its ack: no regrant in the ack cycle
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h1234;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 3) exp_cd = 16'hB234;
            if (c == 7) bus.cpu_req = 1'b0;
            obs($sformatf("hold c%0d", c), !(c == 1 || c == 5),
                c == 1 || c == 2 || c == 5 || c == 6, c == 3 || c == 7, 1'b0);
            chk_data($sformatf("hold c%0d", c));
        end

        // Reset in the ISSUE cycle aborts the access without an ack
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h0ABC;
        tick();
        obs("rst c1", 1'b0, 1'b1, 1'b0, 1'b0);
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        tick();
        reset  = 1'b0;
        exp_cd = 16'h0000;
        exp_dd = 16'h0000;
        obs("rst c2", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rst c2 rom_a", {19'd0, bus.rom_a}, 32'd0);
        chk_data("rst c2");
        for (int c = 3; c <= 5; c++) begin
            tick();
            obs($sformatf("rst c%0d", c), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        run_single("post-rst", 1'b0, 13'h1234, 16'hB234);

        // Address boundary back to back: 0x0000 then 0x1FFF
        bus.cpu_req  = 1'b1;
        bus.cpu_addr = 13'h0000;
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) begin
                exp_cd       = 16'hA000;
                bus.cpu_req  = 1'b0;
                bus.dbg_req  = 1'b1;
                bus.dbg_addr = 13'h1FFF;
            end
            if (c == 6) begin
                exp_dd      = 16'hBFFF;
                bus.dbg_req = 1'b0;
            end
            obs($sformatf("bound c%0d", c), !(c == 1 || c == 4),
                c == 1 || c == 2 || c == 4 || c == 5, c == 3, c == 6);
            chk_data($sformatf("bound c%0d", c));
        end

        // Random traffic against a transaction-level model
        begin : rnd
            int free_at, g_at, ca_at, da_at;
            logic [12:0] ca, da, a_pend, a_exp;
            logic [15:0] c_nxt, d_nxt;
            bit cp, dp, ptr_dbg, ce, de, ack_c, ack_d;
            do_reset();
            free_at = 0;
            g_at    = -10;
            ca_at   = -1;
            da_at   = -1;
            ca      = '0;
            da      = '0;
            a_pend  = '0;
            a_exp   = '0;
            c_nxt   = '0;
            d_nxt   = '0;
            cp      = 1'b0;
            dp      = 1'b0;
            ptr_dbg = 1'b0;
            for (int t = 0; t < 400; t++) begin
                ack_c = (t == ca_at);
                ack_d = (t == da_at);
                if (ack_c) exp_cd = c_nxt;
                if (ack_d) exp_dd = d_nxt;
                if (t == g_at + 1) a_exp = a_pend;
                obs($sformatf("rnd t%0d", t), t != g_at + 1,
                    t > g_at && t < free_at, ack_c, ack_d);
                chk_data($sformatf("rnd t%0d", t));
                chk($sformatf("rnd t%0d rom_a", t), {19'd0, bus.rom_a}, {19'd0, a_exp});

                if (ack_c) cp = ($urandom_range(0, 3) == 0);
                else if (!cp && $urandom_range(0, 2) == 0) begin
                    cp = 1'b1;
                    ca = pick_addr();
                end
                if (ack_d) dp = ($urandom_range(0, 3) == 0);
                else if (!dp && $urandom_range(0, 2) == 0) begin
                    dp = 1'b1;
                    da = pick_addr();
                end
                bus.cpu_req  = cp;
                bus.cpu_addr = ca;
                bus.dbg_req  = dp;
                bus.dbg_addr = da;

                if (t >= free_at) begin
                    ce = cp && !ack_c;
                    de = dp && !ack_d;
                    if (ce || de) begin
                        if (ce && de) w = RR ? ptr_dbg : 1'b0;
                        else w = de;
                        if (w) begin
                            da_at  = t + 3;
                            d_nxt  = rom_word(da);
                            a_pend = da;
                        end else begin
                            ca_at  = t + 3;
                            c_nxt  = rom_word(ca);
                            a_pend = ca;
                        end
                        ptr_dbg = !w;
                        g_at    = t;
                        free_at = t + 3;
                    end
                end
                tick();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
